// File: rtl/wide_reduce_checker.sv
// wide_reduce_checker: sweeps a fixed set of WIDTH-bit patterns and checks their AND/OR/XOR reductions.
// Optional macro WRC_XOR_CHECK_EN enables the XOR reduction and its check.
module wide_reduce_checker #(
  parameter int WIDTH = 68,
  parameter int CNT_W = 16,
  localparam int N = 6 + 2 * WIDTH,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       inj,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] pattern,
  output logic             and_red,
  output logic             or_red,
  output logic             xor_red,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [IDX_W-1:0] first_fail,
  output logic [2:0]       fail_mask
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_ONES = 2'd1;
  localparam logic [1:0] CLS_CLR  = 2'd2;
  localparam logic [1:0] CLS_SET  = 2'd3;

  localparam logic [IDX_W-1:0] K_LAST     = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] WALK0_BASE = IDX_W'(6);
  localparam logic [IDX_W-1:0] WALK1_BASE = IDX_W'(6 + WIDTH);
  localparam logic [IDX_W-1:0] MSB_POS    = IDX_W'(WIDTH - 1);
  localparam logic             X_ONES     = 1'(WIDTH % 2);
  localparam logic             X_CLR      = 1'((WIDTH - 1) % 2);

`ifdef WRC_XOR_CHECK_EN
  localparam logic [2:0] CHK_EN = 3'b111;
`else
  localparam logic [2:0] CHK_EN = 3'b011;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [2:0]       exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [2:0]       mask_q, mask_d;

  logic [IDX_W-1:0] gen_sel, gen_pos;
  logic [1:0]       gen_cls;
  logic [WIDTH-1:0] gen_onehot, gen_pat;
  logic [2:0]       gen_exp;
  logic [2:0]       chk_diff;

  // Pattern class and bit position for the pattern to be loaded on the next edge.
  always_comb begin
    gen_sel = (state_q == S_RUN) ? k_q + IDX_W'(1) : '0;
    gen_pos = '0;
    gen_cls = CLS_ZERO;
    if (gen_sel >= WALK1_BASE) begin
      gen_cls = CLS_SET;
      gen_pos = gen_sel - WALK1_BASE;
    end else if (gen_sel >= WALK0_BASE) begin
      gen_cls = CLS_CLR;
      gen_pos = gen_sel - WALK0_BASE;
    end else begin
      case (gen_sel)
        IDX_W'(1): gen_cls = CLS_CLR;
        IDX_W'(2): gen_cls = CLS_ONES;
        IDX_W'(3): begin gen_cls = CLS_CLR; gen_pos = MSB_POS; end
        IDX_W'(4): begin gen_cls = CLS_SET; gen_pos = MSB_POS; end
        IDX_W'(5): gen_cls = CLS_SET;
        default:   gen_cls = CLS_ZERO;
      endcase
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
    assign gen_onehot[gi] = (gen_pos == IDX_W'(gi));
  end

  // Expected reductions come from the pattern class, never from the register itself.
  always_comb begin
    case (gen_cls)
      CLS_ONES: begin gen_pat = '1;          gen_exp = {X_ONES, 2'b11}; end
      CLS_CLR:  begin gen_pat = ~gen_onehot; gen_exp = {X_CLR, 2'b10}; end
      CLS_SET:  begin gen_pat = gen_onehot;  gen_exp = 3'b110; end
      default:  begin gen_pat = '0;          gen_exp = 3'b000; end
    endcase
  end

  assign and_red = &r_q;
  assign or_red  = |r_q;
`ifdef WRC_XOR_CHECK_EN
  assign xor_red = ^r_q;
`else
  assign xor_red = 1'b0;
`endif

  assign chk_diff = ({xor_red, or_red, and_red} ^ inj ^ exp_q) & CHK_EN;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    mask_d  = mask_q;
    case (state_q)
      S_RUN: begin
        if (chk_diff != 3'b000) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          if (mask_q == 3'b000) first_d = k_q;
          mask_d = mask_q | chk_diff;
        end
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          r_d     = '0;
          k_d     = '0;
          exp_d   = 3'b000;
        end else begin
          k_d   = k_q + IDX_W'(1);
          r_d   = gen_pat;
          exp_d = gen_exp;
        end
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          r_d     = gen_pat;
          exp_d   = gen_exp;
          k_d     = '0;
          cnt_d   = '0;
          first_d = '0;
          mask_d  = 3'b000;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      k_q     <= '0;
      exp_q   <= 3'b000;
      cnt_q   <= '0;
      first_q <= '0;
      mask_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      mask_q  <= mask_d;
    end
  end

  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (cnt_q == '0);
  assign pattern        = r_q;
  assign mismatch_count = cnt_q;
  assign first_fail     = first_q;
  assign fail_mask      = mask_q;

endmodule
